// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared widths, FSM encodings and the base stall/flush priority rules
// for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

   localparam int CTRL_STALL_WIDTH = 5;
   localparam int CTRL_FLUSH_WIDTH = 4;

   localparam logic [1:0] CTRL_ST_RUN   = 2'd0;
   localparam logic [1:0] CTRL_ST_HOLD  = 2'd1;
   localparam logic [1:0] CTRL_ST_DRAIN = 2'd2;
   localparam logic [1:0] CTRL_ST_WFI   = 2'd3;

   typedef struct packed {
      logic [CTRL_STALL_WIDTH-1:0] stall;
      logic [CTRL_FLUSH_WIDTH-1:0] flush;
   } ctrl_vec_t;

   // The oldest stalled stage wins: everything younger holds, the stage behind it gets a bubble.
   function automatic ctrl_vec_t base_rules(input logic dcache_req,
                                            input logic ex_req,
                                            input logic hazard_req,
                                            input logic icache_req);
      ctrl_vec_t v;
      v.stall = '0;
      v.flush = '0;
      if (dcache_req) begin
         v.stall = 5'b01111;
         v.flush = 4'b1000;
      end else if (ex_req) begin
         v.stall = 5'b00111;
         v.flush = 4'b0100;
      end else if (hazard_req) begin
         v.stall = 5'b00011;
         v.flush = 4'b0010;
      end else if (icache_req) begin
         v.stall = 5'b00001;
         v.flush = 4'b0001;
      end
      return v;
   endfunction

endpackage

// File: rtl/ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
module ctrl_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer and fetch redirect owner for the 5-stage pipeline.
// Optional perf counters are enabled with `define PIPE_HAZARD_CTRL_PERF_CNT_EN.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned EXCP_DRAIN_CYC = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Icache_StallReq,
   input  logic        Dcache_StallReq,
   input  logic        EX_StallReq,
   input  logic        DecodeHazard_StallReq,
   input  logic        EX_BranchFlag,
   input  logic [31:0] EX_BranchPC,
   input  logic        Csr_ExcpFlag,
   input  logic [31:0] Csr_Evec,
   input  logic        Csr_Memflush,
   input  logic        Decode_WfiFlag,
   input  logic        Csr_WFIClrFlag,
   output logic [4:0]  Ctrl_Stall,
   output logic [3:0]  Flush,
   output logic        Ctrl_RedirectValid,
   output logic [31:0] Ctrl_RedirectPC,
   output logic [1:0]  Ctrl_State,
   output logic [31:0] Ctrl_StallCnt,
   output logic [31:0] Ctrl_FlushCnt
);

   localparam logic [3:0] DRAIN_LOAD = 4'(EXCP_DRAIN_CYC);
   localparam logic       DRAIN_EN   = (EXCP_DRAIN_CYC != 0);

   logic [1:0]  state_q, state_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        pend_excp_q, pend_excp_d;
   logic [3:0]  drain_cnt_q, drain_cnt_d;

   ctrl_vec_t   base;
   logic [4:0]  stall;
   logic [3:0]  flush;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        br_ok;
   logic        can_issue;
   logic        event_go;
   logic        hold_excp;
   logic [31:0] event_pc;

   // Per-state overlay on the base rules, then exception/branch handling for every state except HOLD.
   always_comb begin
      base         = base_rules(Dcache_StallReq, EX_StallReq, DecodeHazard_StallReq, Icache_StallReq);
      stall        = base.stall;
      flush        = base.flush;
      redir_valid  = 1'b0;
      redir_pc     = '0;
      state_d      = state_q;
      pend_valid_d = pend_valid_q;
      pend_pc_d    = pend_pc_q;
      pend_excp_d  = pend_excp_q;
      drain_cnt_d  = drain_cnt_q;
      br_ok        = EX_BranchFlag & ~EX_StallReq & ~Dcache_StallReq;
      can_issue    = ~Icache_StallReq & ~Dcache_StallReq;
      event_go     = 1'b0;
      hold_excp    = pend_excp_q | Csr_ExcpFlag;
      event_pc     = Csr_ExcpFlag ? Csr_Evec : EX_BranchPC;

      case (state_q)
         CTRL_ST_RUN: begin
            if (Decode_WfiFlag) begin
               state_d = CTRL_ST_WFI;
            end
         end
         CTRL_ST_DRAIN: begin
            flush[0] = 1'b1;
            if (drain_cnt_q <= 4'd1) begin
               state_d = CTRL_ST_RUN;
            end else begin
               drain_cnt_d = drain_cnt_q - 4'd1;
            end
         end
         CTRL_ST_WFI: begin
            stall = base.stall | 5'b00011;
            flush = {base.flush[3:2], 2'b10};
            if (Csr_WFIClrFlag) begin
               state_d = CTRL_ST_RUN;
            end
         end
         CTRL_ST_HOLD: begin
            // A late exception replaces the parked branch target; branches are ignored here.
            if (Csr_ExcpFlag) begin
               stall       = '0;
               flush[2:0]  = 3'b111;
               flush[3]    = Csr_Memflush;
               pend_pc_d   = Csr_Evec;
               pend_excp_d = 1'b1;
            end
            flush[1:0] = 2'b11;
            if (can_issue) begin
               redir_valid  = 1'b1;
               redir_pc     = Csr_ExcpFlag ? Csr_Evec : pend_pc_q;
               pend_valid_d = 1'b0;
               pend_excp_d  = 1'b0;
               if (hold_excp && DRAIN_EN) begin
                  state_d     = CTRL_ST_DRAIN;
                  drain_cnt_d = DRAIN_LOAD;
               end else begin
                  state_d = CTRL_ST_RUN;
               end
            end else begin
               stall[0] = 1'b1;
            end
         end
         default: state_d = CTRL_ST_RUN;
      endcase

      if (state_q != CTRL_ST_HOLD) begin
         if (Csr_ExcpFlag) begin
            stall      = '0;
            flush[2:0] = 3'b111;
            flush[3]   = Csr_Memflush;
            event_go   = 1'b1;
         end else if (br_ok && (state_q != CTRL_ST_WFI)) begin
            stall[1:0] = 2'b00;
            flush[1:0] = 2'b11;
            event_go   = 1'b1;
         end

         // Issue now if fetch can take it, otherwise park the target and wait in HOLD.
         if (event_go) begin
            if (can_issue) begin
               redir_valid = 1'b1;
               redir_pc    = event_pc;
               if (Csr_ExcpFlag && DRAIN_EN) begin
                  state_d     = CTRL_ST_DRAIN;
                  drain_cnt_d = DRAIN_LOAD;
               end else if (Csr_ExcpFlag || (state_q == CTRL_ST_RUN)) begin
                  state_d = CTRL_ST_RUN;
               end
            end else begin
               pend_valid_d = 1'b1;
               pend_pc_d    = event_pc;
               pend_excp_d  = Csr_ExcpFlag;
               state_d      = CTRL_ST_HOLD;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= CTRL_ST_RUN;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= '0;
         pend_excp_q  <= 1'b0;
         drain_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_pc_q    <= pend_pc_d;
         pend_excp_q  <= pend_excp_d;
         drain_cnt_q  <= drain_cnt_d;
      end
   end

   // While reset is held the whole pipe is bubbled and fetch gets no redirect.
   assign Ctrl_Stall         = rst_n ? stall : '0;
   assign Flush              = rst_n ? flush : 4'b1111;
   assign Ctrl_RedirectValid = rst_n & redir_valid;
   assign Ctrl_RedirectPC    = rst_n ? redir_pc : '0;
   assign Ctrl_State         = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
   ctrl_sat_counter #(.WIDTH(32)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (Ctrl_Stall[0]),
      .cnt   (Ctrl_StallCnt)
   );

   ctrl_sat_counter #(.WIDTH(32)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (Ctrl_RedirectValid),
      .cnt   (Ctrl_FlushCnt)
   );
`else
   assign Ctrl_StallCnt = '0;
   assign Ctrl_FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: stall priority, redirects, HOLD/DRAIN/WFI and reset.
// Honours `define PIPE_HAZARD_CTRL_PERF_CNT_EN for the counter checks.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Icache_StallReq = 1'b0;
   logic        Dcache_StallReq = 1'b0;
   logic        EX_StallReq = 1'b0;
   logic        DecodeHazard_StallReq = 1'b0;
   logic        EX_BranchFlag = 1'b0;
   logic [31:0] EX_BranchPC = '0;
   logic        Csr_ExcpFlag = 1'b0;
   logic [31:0] Csr_Evec = '0;
   logic        Csr_Memflush = 1'b0;
   logic        Decode_WfiFlag = 1'b0;
   logic        Csr_WFIClrFlag = 1'b0;
   logic [4:0]  Ctrl_Stall;
   logic [3:0]  Flush;
   logic        Ctrl_RedirectValid;
   logic [31:0] Ctrl_RedirectPC;
   logic [1:0]  Ctrl_State;
   logic [31:0] Ctrl_StallCnt;
   logic [31:0] Ctrl_FlushCnt;

   int checkCount = 0;
   int errorCount = 0;

   pipe_hazard_ctrl #(.EXCP_DRAIN_CYC(1)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .Icache_StallReq       (Icache_StallReq),
      .Dcache_StallReq       (Dcache_StallReq),
      .EX_StallReq           (EX_StallReq),
      .DecodeHazard_StallReq (DecodeHazard_StallReq),
      .EX_BranchFlag         (EX_BranchFlag),
      .EX_BranchPC           (EX_BranchPC),
      .Csr_ExcpFlag          (Csr_ExcpFlag),
      .Csr_Evec              (Csr_Evec),
      .Csr_Memflush          (Csr_Memflush),
      .Decode_WfiFlag        (Decode_WfiFlag),
      .Csr_WFIClrFlag        (Csr_WFIClrFlag),
      .Ctrl_Stall            (Ctrl_Stall),
      .Flush                 (Flush),
      .Ctrl_RedirectValid    (Ctrl_RedirectValid),
      .Ctrl_RedirectPC       (Ctrl_RedirectPC),
      .Ctrl_State            (Ctrl_State),
      .Ctrl_StallCnt         (Ctrl_StallCnt),
      .Ctrl_FlushCnt         (Ctrl_FlushCnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's worth of inputs and let the combinational outputs settle.
   task automatic applyStimulus(input logic dcache, input logic ex, input logic hazard, input logic icache,
                                input logic branch, input logic [31:0] branchPc,
                                input logic excp, input logic [31:0] evec, input logic memflush,
                                input logic wfi, input logic wfiClr);
      Dcache_StallReq       = dcache;
      EX_StallReq           = ex;
      DecodeHazard_StallReq = hazard;
      Icache_StallReq       = icache;
      EX_BranchFlag         = branch;
      EX_BranchPC           = branchPc;
      Csr_ExcpFlag          = excp;
      Csr_Evec              = evec;
      Csr_Memflush          = memflush;
      Decode_WfiFlag        = wfi;
      Csr_WFIClrFlag        = wfiClr;
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      checkOutput("rst_stall", 32'(Ctrl_Stall), 32'h00);
      checkOutput("rst_flush", 32'(Flush), 32'hF);
      checkOutput("rst_valid", 32'(Ctrl_RedirectValid), 32'h0);
      checkOutput("rst_pc", Ctrl_RedirectPC, 32'h0);
      checkOutput("rst_state", 32'(Ctrl_State), 32'h0);
      #10 rst_n = 1'b1;

      nextCycle(); applyStimulus(1, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      checkOutput("dc_ex_stall", 32'(Ctrl_Stall), 32'h0F);
      checkOutput("dc_ex_flush", 32'(Flush), 32'h8);
      checkOutput("dc_ex_state", 32'(Ctrl_State), 32'h0);
      nextCycle(); applyStimulus(0, 1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      checkOutput("ex_stall", 32'(Ctrl_Stall), 32'h07);
      checkOutput("ex_flush", 32'(Flush), 32'h4);
      nextCycle(); applyStimulus(0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      checkOutput("hz_stall", 32'(Ctrl_Stall), 32'h03);
      checkOutput("hz_flush", 32'(Flush), 32'h2);
      nextCycle(); applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      checkOutput("ic_stall", 32'(Ctrl_Stall), 32'h01);
      checkOutput("ic_flush", 32'(Flush), 32'h1);
      nextCycle(); idle();
      checkOutput("none_stall", 32'(Ctrl_Stall), 32'h00);
      checkOutput("none_flush", 32'(Flush), 32'h0);

      nextCycle(); applyStimulus(0, 0, 0, 0, 1, 32'h100, 0, 32'h0, 0, 0, 0);
      checkOutput("br_valid", 32'(Ctrl_RedirectValid), 32'h1);
      checkOutput("br_pc", Ctrl_RedirectPC, 32'h100);
      checkOutput("br_flush", 32'(Flush), 32'h3);
      checkOutput("br_stall", 32'(Ctrl_Stall), 32'h00);
      nextCycle(); idle();
      checkOutput("br_state", 32'(Ctrl_State), 32'h0);
      checkOutput("br_valid_off", 32'(Ctrl_RedirectValid), 32'h0);
      nextCycle(); applyStimulus(0, 1, 0, 0, 1, 32'h180, 0, 32'h0, 0, 0, 0);
      checkOutput("br_ex_valid", 32'(Ctrl_RedirectValid), 32'h0);
      checkOutput("br_ex_stall", 32'(Ctrl_Stall), 32'h07);
      checkOutput("br_ex_flush", 32'(Flush), 32'h4);
      nextCycle(); applyStimulus(0, 0, 1, 0, 1, 32'h1C0, 0, 32'h0, 0, 0, 0);
      checkOutput("br_hz_state", 32'(Ctrl_State), 32'h0);
      checkOutput("br_hz_stall", 32'(Ctrl_Stall), 32'h00);
      checkOutput("br_hz_pc", Ctrl_RedirectPC, 32'h1C0);

      nextCycle(); applyStimulus(0, 0, 0, 1, 1, 32'h200, 0, 32'h0, 0, 0, 0);
      checkOutput("brst_valid", 32'(Ctrl_RedirectValid), 32'h0);
      checkOutput("brst_flush", 32'(Flush), 32'h3);
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         applyStimulus(0, 0, 0, 1, (i == 1), 32'h300, 0, 32'h0, 0, 0, 0);
         checkOutput("hold_state", 32'(Ctrl_State), 32'h1);
         checkOutput("hold_valid", 32'(Ctrl_RedirectValid), 32'h0);
         checkOutput("hold_stall0", 32'(Ctrl_Stall[0]), 32'h1);
         checkOutput("hold_flush10", 32'(Flush[1:0]), 32'h3);
      end
      nextCycle(); idle();
      checkOutput("rel_valid", 32'(Ctrl_RedirectValid), 32'h1);
      checkOutput("rel_pc", Ctrl_RedirectPC, 32'h200);
      nextCycle(); idle();
      checkOutput("rel_state", 32'(Ctrl_State), 32'h0);

      nextCycle(); applyStimulus(0, 0, 0, 1, 1, 32'h200, 0, 32'h0, 0, 0, 0);
      nextCycle(); applyStimulus(0, 0, 0, 1, 0, 32'h0, 1, 32'h8, 0, 0, 0);
      checkOutput("hx_state", 32'(Ctrl_State), 32'h1);
      checkOutput("hx_valid", 32'(Ctrl_RedirectValid), 32'h0);
      checkOutput("hx_flush", 32'(Flush), 32'h7);
      nextCycle(); idle();
      checkOutput("hx_rel_valid", 32'(Ctrl_RedirectValid), 32'h1);
      checkOutput("hx_rel_pc", Ctrl_RedirectPC, 32'h8);
      nextCycle(); idle();
      checkOutput("drain_state", 32'(Ctrl_State), 32'h2);
      checkOutput("drain_flush", 32'(Flush), 32'h1);
      checkOutput("drain_stall", 32'(Ctrl_Stall), 32'h00);
      nextCycle(); idle();
      checkOutput("drain_end_state", 32'(Ctrl_State), 32'h0);
      checkOutput("drain_end_flush", 32'(Flush), 32'h0);

      nextCycle(); applyStimulus(0, 0, 1, 0, 1, 32'h100, 1, 32'h40, 1, 0, 0);
      checkOutput("ex_now_stall", 32'(Ctrl_Stall), 32'h00);
      checkOutput("ex_now_flush", 32'(Flush), 32'hF);
      checkOutput("ex_now_valid", 32'(Ctrl_RedirectValid), 32'h1);
      checkOutput("ex_now_pc", Ctrl_RedirectPC, 32'h40);
      nextCycle(); idle();
      checkOutput("ex_now_drain", 32'(Ctrl_State), 32'h2);
      nextCycle(); idle();
      checkOutput("ex_now_run", 32'(Ctrl_State), 32'h0);

      nextCycle(); applyStimulus(1, 0, 0, 0, 0, 32'h0, 1, 32'h80, 0, 0, 0);
      checkOutput("ex_dc_stall", 32'(Ctrl_Stall), 32'h00);
      checkOutput("ex_dc_flush", 32'(Flush), 32'h7);
      checkOutput("ex_dc_valid", 32'(Ctrl_RedirectValid), 32'h0);
      nextCycle(); idle();
      checkOutput("ex_dc_hold", 32'(Ctrl_State), 32'h1);
      checkOutput("ex_dc_rel_pc", Ctrl_RedirectPC, 32'h80);
      checkOutput("ex_dc_rel_valid", 32'(Ctrl_RedirectValid), 32'h1);
      nextCycle(); idle();
      checkOutput("ex_dc_drain", 32'(Ctrl_State), 32'h2);
      nextCycle(); idle();

      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0);
      checkOutput("wfi_in_stall", 32'(Ctrl_Stall), 32'h00);
      for (int i = 0; i < 5; i++) begin
         nextCycle(); idle();
         checkOutput("wfi_state", 32'(Ctrl_State), 32'h3);
         checkOutput("wfi_stall", 32'(Ctrl_Stall), 32'h03);
         checkOutput("wfi_flush", 32'(Flush), 32'h2);
      end
      nextCycle(); applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
      checkOutput("wfi_clr_state", 32'(Ctrl_State), 32'h3);
      nextCycle(); idle();
      checkOutput("wfi_exit_state", 32'(Ctrl_State), 32'h0);
      checkOutput("wfi_exit_stall", 32'(Ctrl_Stall), 32'h00);

      nextCycle(); applyStimulus(0, 0, 0, 1, 1, 32'h200, 0, 32'h0, 0, 0, 0);
      nextCycle(); applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      checkOutput("pre_rst_hold", 32'(Ctrl_State), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_stall", 32'(Ctrl_Stall), 32'h00);
      checkOutput("mid_rst_flush", 32'(Flush), 32'hF);
      checkOutput("mid_rst_valid", 32'(Ctrl_RedirectValid), 32'h0);
      checkOutput("mid_rst_state", 32'(Ctrl_State), 32'h0);
      #2 rst_n = 1'b1;
      idle();
      checkOutput("post_rst_valid", 32'(Ctrl_RedirectValid), 32'h0);
      nextCycle(); idle();
      checkOutput("post_rst_state", 32'(Ctrl_State), 32'h0);
      checkOutput("post_rst_valid2", 32'(Ctrl_RedirectValid), 32'h0);

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      repeat (10) @(posedge clk);
      #1;
      idle();
      checkOutput("perf_stall_cnt", Ctrl_StallCnt, 32'd10);
      checkOutput("perf_flush_cnt0", Ctrl_FlushCnt, 32'd0);
      applyStimulus(0, 0, 0, 0, 1, 32'h100, 0, 32'h0, 0, 0, 0);
      nextCycle(); idle();
      checkOutput("perf_flush_cnt1", Ctrl_FlushCnt, 32'd1);
`else
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
      nextCycle(); idle();
      checkOutput("perf_stall_off", Ctrl_StallCnt, 32'd0);
      checkOutput("perf_flush_off", Ctrl_FlushCnt, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
